// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int BUSY_CNT_W = 3;

    localparam logic [1:0] WB_SRC_LOAD = 2'b01;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        NONE,
        LOAD_USE,
        SCOREBOARD,
        MC_BUSY
    } stall_reason_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register load-latency counters and multi-cycle pending bits,
// with combinational lookup for the ID source operands.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ld_set,
    input  reg_addr_t                           ld_rd,
    input  logic                                mc_start,
    input  reg_addr_t                           mc_rd,
    input  logic                                mc_done,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  rs,
    output logic [NUM_SRC-1:0]                  rs_busy,
    output logic                                mc_busy
);

    localparam logic [BUSY_CNT_W-1:0] LD_INIT = BUSY_CNT_W'(LOAD_LAT - 1);
    localparam logic [BUSY_CNT_W-1:0] CNT_ONE = BUSY_CNT_W'(1);

    logic [NUM_REGS-1:0][BUSY_CNT_W-1:0] busy_cnt;
    logic [NUM_REGS-1:0]                 mc_pend;
    reg_addr_t                           mc_inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (busy_cnt[i] != '0)
                    busy_cnt[i] <= busy_cnt[i] - CNT_ONE;
            end
            if (ld_set)
                busy_cnt[ld_rd] <= LD_INIT;
        end
    end

    // Start is applied after done so a back-to-back op keeps its pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_pend     <= '0;
            mc_busy     <= 1'b0;
            mc_inflight <= '0;
        end else begin
            if (mc_done && mc_busy) begin
                mc_pend[mc_inflight] <= 1'b0;
                mc_busy              <= 1'b0;
            end
            if (mc_start) begin
                if (mc_rd != '0)
                    mc_pend[mc_rd] <= 1'b1;
                mc_busy     <= 1'b1;
                mc_inflight <= mc_rd;
            end
        end
    end

    always_comb begin
        rs_busy = '0;
        for (int s = 0; s < NUM_SRC; s++)
            rs_busy[s] = (busy_cnt[rs[s]] != '0) || mc_pend[rs[s]];
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generation for load-use, scoreboard and multi-cycle hazards,
// plus saturating stall and flush performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]                  id_rs_used,
    input  logic                                id_is_mc,
    input  logic                                ex_valid,
    input  logic [REG_ADDR_W-1:0]               ex_rd,
    input  logic [1:0]                          ex_reg_write_src,
    input  logic                                ex_is_mc,
    input  logic                                mc_start,
    input  logic [REG_ADDR_W-1:0]               mc_rd,
    input  logic                                mc_done,
    input  logic                                BranchExecuted,
    input  logic                                perf_clr,
    output logic                                if_stall,
    output logic                                id_stall,
    output logic                                id_flush,
    output logic                                ex_flush,
    output stall_reason_e                       stall_reason,
    output logic [PERF_W-1:0]                   stall_cnt,
    output logic [PERF_W-1:0]                   flush_cnt
);

    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [NUM_SRC-1:0] live;
    logic [NUM_SRC-1:0] ex_match;
    logic [NUM_SRC-1:0] rs_busy;
    logic               ld_qual;
    logic               load_use;
    logic               sb_haz;
    logic               mc_haz;
    logic               mc_busy;
    logic               raw_stall;

    hazard_scoreboard #(
        .NUM_SRC  (NUM_SRC),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_set   (ld_qual),
        .ld_rd    (ex_rd),
        .mc_start (mc_start),
        .mc_rd    (mc_rd),
        .mc_done  (mc_done),
        .rs       (id_rs),
        .rs_busy  (rs_busy),
        .mc_busy  (mc_busy)
    );

    always_comb begin
        live     = '0;
        ex_match = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            live[s]     = id_rs_used[s] && (id_rs[s] != '0);
            ex_match[s] = (id_rs[s] == ex_rd);
        end
    end

    assign ld_qual   = ex_valid && (ex_reg_write_src == WB_SRC_LOAD)
                     && (ex_rd != '0);
    assign load_use  = ld_qual && |(live & ex_match);
    assign sb_haz    = |(live & rs_busy);
    assign mc_haz    = id_is_mc && (mc_busy || (ex_valid && ex_is_mc));
    assign raw_stall = load_use || sb_haz || mc_haz;

    // A resolved branch squashes the stalled instruction anyway.
    assign if_stall = raw_stall && !BranchExecuted;
    assign id_stall = if_stall;
    assign id_flush = BranchExecuted;
    assign ex_flush = BranchExecuted || if_stall;

    always_comb begin
        stall_reason = NONE;
        if (if_stall) begin
            priority case (1'b1)
                load_use: stall_reason = LOAD_USE;
                sb_haz:   stall_reason = SCOREBOARD;
                default:  stall_reason = MC_BUSY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (if_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_ONE;
            if (BranchExecuted && (flush_cnt != '1))
                flush_cnt <= flush_cnt + PERF_ONE;
        end
    end

endmodule
